brute_force_generator: RTL
==========================

# brute_force_generator

Fully synchronous, parametrised password-candidate generator for the brute-force cracking pipeline. It sits between the controller and the hash/compare stage. It enumerates every string over a configurable character range, length by length, as a single-cycle-carry odometer, with no derived or rippled clocks. The first character uses a programmable start and stride, so N instances can partition the search space. Candidates leave through a valid/ready handshake; `done` flags exhaustion.

## Interface
- `MAX_CHARS`, default 16: longest candidate, in characters (≥1).
- `MIN_CHARS`, default 1: first length emitted (1..MAX_CHARS).
- `CHAR_LO`, default 8'h20: lowest character code.
- `CHAR_HI`, default 8'h7E: highest character code (> CHAR_LO).
- `STRIDE_W`, default 3: width of `stride`.
- `clock`  in  1: sole clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: pulse. Latches configuration and (re)starts the enumeration.
- `abort`  in  1: pulse. Controller found a match; stop and return to IDLE.
- `start_char`  in  8: first value of character 0. Sampled on `start`.
- `stride`  in  STRIDE_W: step of character 0. Sampled on `start`.
- `ready`  in  1: downstream accepts the candidate.
- `valid`  out  1: `password`/`num_chars` hold a candidate.
- `password`  out  8*MAX_CHARS: candidate. Character i is at [8i+7:8i]; character 0 is the least significant and fastest-changing.
- `num_chars`  out  $clog2(MAX_CHARS+1): active length of `password`, in characters.
- `done`  out  1: search space exhausted.

## Operation
- FSM states:
  - IDLE: `valid`=0, `done`=0.
  - RUN: `valid`=1.
  - DONE: `valid`=0, `done`=1.
- Configuration latch on `start`:
  - stride=0 is stored as 1.
  - start_char < CHAR_LO is stored as CHAR_LO; start_char > CHAR_HI is stored as CHAR_HI.
- Load (on `start` in any state): length=MIN_CHARS, character 0=start_char, characters 1..length-1=CHAR_LO, all higher bytes 8'h00. Next state RUN.
- Advance (RUN with valid&&ready):
  - Character 0: compute c+stride in 9 bits. If the sum > CHAR_HI, wrap to the latched start_char and carry; otherwise take the sum with no carry.
  - Character i≥1, only when it receives a carry: if c==CHAR_HI, wrap to CHAR_LO and carry onward; otherwise c+1, carry stops.
  - All carries resolve in the same cycle.
- Carry out of the top active character:
  - If length < MAX_CHARS: length+1, reload as for Load at the new length.
  - If length == MAX_CHARS: go to DONE, `valid`=0, `password` unchanged.
- `abort` in RUN or DONE goes to IDLE, `valid`=0, `done`=0. `password` and `num_chars` keep their last value.
- Priority: reset > abort > start > advance. `start` asserted together with `abort` is ignored.
- Bytes at or above `num_chars` always read 8'h00.

## Timing
- Reset values: state IDLE, `valid`=0, `done`=0, `password`=0, `num_chars`=0, stored config start_char=CHAR_LO, stride=1.
- `start` sampled at edge t: first candidate and `valid`=1 visible after edge t; `num_chars`=MIN_CHARS.
- Handshake at edge t: the next candidate is visible after t. With `ready` held high, throughput is one candidate per cycle, including length growth.
- `ready`=0: `password`, `num_chars` and `valid` are held stable. `valid` never drops without a handshake, except on abort or reset.
- Exhaustion: the handshake on the last candidate at edge t gives `valid`=0 and `done`=1 after t.
- Reset mid-RUN: outputs take their reset values at the next edge; in-flight candidate is discarded.
- `start` in RUN: restarts with the new configuration next cycle. The unaccepted candidate is dropped.

## Test plan
- Full enumeration: MAX_CHARS=2, MIN_CHARS=1, CHAR_LO='a', CHAR_HI='c', start_char='a', stride=1, `ready`=1.
  - Required sequence: 'a','b','c', then 16'h6161, 16'h6162, 16'h6163, 16'h6261 … 16'h6363.
  - Exactly 12 valid cycles, `num_chars` 1→2 at the 4th candidate, then `done`=1.
- Stride partition: same params, start_char='b', stride=2.
  - Required candidates: 'b', 16'h6162, 16'h6262, 16'h6362; then `done`.
- Backpressure: hold `ready`=0 for 3 cycles on candidate 16'h6162.
  - Required: output stable and `valid`=1 throughout; the next candidate is 16'h6163 one cycle after `ready` rises.
- Config sanitising: stride=0 and start_char=8'h10.
  - Required: behaves as stride=1, start_char='a'; sequence identical to the full-enumeration case.
- Abort and reset:
  - `abort` on the 5th candidate → IDLE, `valid`=0, `done`=0.
  - `start` together with `abort` → stays IDLE.
  - `reset` during RUN → all outputs 0 next cycle.
- Restart from DONE: `start` in DONE → `done`=0, first candidate reloaded next cycle.

Source files
------------

// File: rtl/brute_force_generator.sv
`default_nettype none
// brute_force_generator: single-clock odometer enumerating candidate strings length by length.
// Rev 1.0
module brute_force_generator #(
    parameter int         MAX_CHARS = 16,
    parameter int         MIN_CHARS = 1,
    parameter logic [7:0] CHAR_LO   = 8'h20,
    parameter logic [7:0] CHAR_HI   = 8'h7E,
    parameter int         STRIDE_W  = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [7:0]                         start_char_i,
    input  logic [STRIDE_W-1:0]                stride_i,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic [8*MAX_CHARS-1:0]             password_o,
    output logic [$clog2(MAX_CHARS+1)-1:0]     num_chars_o,
    output logic                               done_o
);

    localparam int NW = $clog2(MAX_CHARS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NW-1:0] LEN_MIN = NW'(MIN_CHARS);
    localparam logic [NW-1:0] LEN_MAX = NW'(MAX_CHARS);

    logic [1:0]                  state_q, state_d;
    logic [7:0]                  cfg_start_q, cfg_start_d;
    logic [STRIDE_W-1:0]         cfg_stride_q, cfg_stride_d;
    logic [MAX_CHARS-1:0][7:0]   chars_q, chars_d;
    logic [NW-1:0]               len_q, len_d;

    logic [7:0]                  start_san;
    logic [STRIDE_W-1:0]         stride_san;
    logic [MAX_CHARS-1:0][7:0]   adv_chars;
    logic                        adv_carry;
    logic                        carry;
    logic [8:0]                  sum0;

    // Fresh candidate of a given length: char 0 seeded, the rest at the bottom of the range.
    function automatic logic [MAX_CHARS-1:0][7:0] reload(input logic [NW-1:0] len,
                                                         input logic [7:0]    c0);
        logic [MAX_CHARS-1:0][7:0] r;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (i == 0)
                r[i] = c0;
            else if (i < int'(len))
                r[i] = CHAR_LO;
            else
                r[i] = 8'h00;
        end
        return r;
    endfunction

    always_comb begin
        start_san = start_char_i;
        if (start_char_i < CHAR_LO)
            start_san = CHAR_LO;
        else if (start_char_i > CHAR_HI)
            start_san = CHAR_HI;
        stride_san = (stride_i == '0) ? STRIDE_W'(1) : stride_i;
    end

    // Whole carry chain resolves combinationally; inactive bytes never consume the carry.
    always_comb begin
        adv_chars = chars_q;
        sum0      = {1'b0, chars_q[0]} + 9'(cfg_stride_q);
        if (sum0 > {1'b0, CHAR_HI}) begin
            adv_chars[0] = cfg_start_q;
            carry        = 1'b1;
        end else begin
            adv_chars[0] = sum0[7:0];
            carry        = 1'b0;
        end
        for (int i = 1; i < MAX_CHARS; i++) begin
            if (carry && (i < int'(len_q))) begin
                if (chars_q[i] == CHAR_HI) begin
                    adv_chars[i] = CHAR_LO;
                end else begin
                    adv_chars[i] = chars_q[i] + 8'd1;
                    carry        = 1'b0;
                end
            end
        end
        adv_carry = carry;
    end

    always_comb begin
        state_d      = state_q;
        cfg_start_d  = cfg_start_q;
        cfg_stride_d = cfg_stride_q;
        chars_d      = chars_q;
        len_d        = len_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else if (start_i) begin
            cfg_start_d  = start_san;
            cfg_stride_d = stride_san;
            len_d        = LEN_MIN;
            chars_d      = reload(LEN_MIN, start_san);
            state_d      = S_RUN;
        end else if ((state_q == S_RUN) && ready_i) begin
            if (!adv_carry) begin
                chars_d = adv_chars;
            end else if (len_q < LEN_MAX) begin
                len_d   = len_q + NW'(1);
                chars_d = reload(len_q + NW'(1), cfg_start_q);
            end else begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cfg_start_q  <= CHAR_LO;
            cfg_stride_q <= STRIDE_W'(1);
            chars_q      <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            cfg_start_q  <= cfg_start_d;
            cfg_stride_q <= cfg_stride_d;
            chars_q      <= chars_d;
            len_q        <= len_d;
        end
    end

    assign valid_o     = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign password_o  = chars_q;
    assign num_chars_o = len_q;

endmodule
`default_nettype wire
